// File: rtl/series_to_parallel.sv
// Serial-to-parallel soft-bit assembler: packs modOrder signed samples into one word,
// first sample in the highest used slot, with flush of partial words and illegal-order flagging.
module series_to_parallel #(
    parameter int maxWordOut = 6,
    parameter int bitW       = 5
) (
    input  logic                               clk_h,
    input  logic                               rst,
    input  logic                               ival,
    input  logic signed [bitW-1:0]             ibit,
    input  logic        [3:0]                  modOrder,
    input  logic                               iflush,
    output logic                               oval,
    output logic signed [maxWordOut*bitW-1:0]  obit,
    output logic        [3:0]                  olen,
    output logic                               opart,
    output logic                               oerr
);

    localparam logic [3:0] MAX_ORD = 4'(maxWordOut);

    logic signed [bitW-1:0] shd     [maxWordOut];
    logic signed [bitW-1:0] shd_nxt [maxWordOut];

    logic [3:0] idx;
    logic [3:0] ord;
    logic [3:0] eff_ord;
    logic [3:0] slot;
    logic [3:0] cnt_nxt;
    logic       start;
    logic       illegal;
    logic       accept;
    logic       complete;
    logic       flush;
    logic       emit;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        start    = ival && (idx == 4'd0);
        illegal  = start && ((modOrder == 4'd0) || (modOrder > MAX_ORD));
        accept   = ival && !illegal;
        // The first sample of a word uses the live modOrder; later samples use the latched order.
        eff_ord  = (idx == 4'd0) ? modOrder : ord;
        slot     = eff_ord - 4'd1 - idx;
        cnt_nxt  = idx + {3'd0, accept};
        complete = accept && (cnt_nxt == eff_ord);
        flush    = iflush && (cnt_nxt != 4'd0) && !complete;
        emit     = complete || flush;
        for (int k = 0; k < maxWordOut; k++) begin
            shd_nxt[k] = (accept && (slot == 4'(k))) ? ibit : shd[k];
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            idx   <= '0;
            ord   <= '0;
            oval  <= 1'b0;
            obit  <= '0;
            olen  <= '0;
            opart <= 1'b0;
            oerr  <= 1'b0;
            // NOTE: the shadow buffer is a handful of registers and must be clean for a fresh word, so it is reset.
            for (int k = 0; k < maxWordOut; k++) begin
                shd[k] <= '0;
            end
        end else begin
            oval  <= emit;
            opart <= flush;
            olen  <= emit ? cnt_nxt : 4'd0;
            oerr  <= illegal;
            for (int k = 0; k < maxWordOut; k++) begin
                obit[k*bitW +: bitW] <= emit ? shd_nxt[k] : '0;
                shd[k]               <= emit ? '0 : shd_nxt[k];
            end
            idx <= emit ? 4'd0 : cnt_nxt;
            if (start && accept) begin
                ord <= modOrder;
            end
        end
    end

endmodule

// File: tb/tb_series_to_parallel.sv
// Scoreboard bench for series_to_parallel: expected words are queued as stimulus is driven
// and compared whenever the DUT pulses oval.
module tb_series_to_parallel;

    typedef struct {
        logic [29:0] word;
        logic [3:0]  len;
        logic        part;
    } exp_t;

    logic               clk_h = 1'b0;
    logic               rst   = 1'b1;
    logic               ival  = 1'b0;
    logic signed [4:0]  ibit  = '0;
    logic        [3:0]  modOrder = '0;
    logic               iflush = 1'b0;
    logic               oval;
    logic signed [29:0] obit;
    logic        [3:0]  olen;
    logic               opart;
    logic               oerr;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   drv_cyc  = 0;
    int   err_seen = 0;
    exp_t sb[$];
    int   oval_cyc[$];

    series_to_parallel #(.maxWordOut(6), .bitW(5)) dut (
        .clk_h(clk_h), .rst(rst), .ival(ival), .ibit(ibit), .modOrder(modOrder),
        .iflush(iflush), .oval(oval), .obit(obit), .olen(olen), .opart(opart), .oerr(oerr)
    );

    always #5 clk_h = ~clk_h;
    always @(posedge clk_h) cycle++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [29:0] pack(input int s5, input int s4, input int s3,
                                         input int s2, input int s1, input int s0);
        return {5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    task automatic push(input logic [29:0] w, input logic [3:0] l, input logic p);
        exp_t e;
        e.word = w; e.len = l; e.part = p;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input int b, input logic [3:0] m, input logic f);
        @(posedge clk_h);
        #1;
        ival = v; ibit = 5'(b); modOrder = m; iflush = f;
        drv_cyc = cycle;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 4'd0, 1'b0);
    endtask

    // Scoreboard side: every oval pulse must match the oldest queued word.
    always @(negedge clk_h) begin
        if (!rst) begin
            if (oval) begin
                oval_cyc.push_back(cycle);
                if (sb.size() == 0) begin
                    check("unexpected_oval", {31'd0, oval}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("obit",  {2'd0, obit},   {2'd0, e.word});
                    check("olen",  {28'd0, olen},  {28'd0, e.len});
                    check("opart", {31'd0, opart}, {31'd0, e.part});
                end
            end
            if (oerr) err_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_cyc;
        repeat (3) @(posedge clk_h);
        @(negedge clk_h);
        check("rst_oval",  {31'd0, oval},  32'd0);
        check("rst_obit",  {2'd0, obit},   32'd0);
        check("rst_olen",  {28'd0, olen},  32'd0);
        check("rst_opart", {31'd0, opart}, 32'd0);
        check("rst_oerr",  {31'd0, oerr},  32'd0);
        @(posedge clk_h);
        #1 rst = 1'b0;
        idle(2);

        // T1: order 4, samples 1..4, latency one cycle.
        for (int i = 1; i <= 4; i++) drive(1'b1, i, 4'd4, 1'b0);
        push(pack(0, 0, 1, 2, 3, 4), 4'd4, 1'b0);
        t1_cyc = drv_cyc;
        idle(3);
        check("t1_latency", 32'(oval_cyc.size() > 0 ? oval_cyc[$] : -1), 32'(t1_cyc + 1));

        // T2: two order-6 words back to back, modOrder wiggled to 2 mid-word.
        for (int i = 0; i < 12; i++) begin
            logic [3:0] m;
            m = ((i % 6) >= 2 && (i % 6) <= 4) ? 4'd2 : 4'd6;
            drive(1'b1, (i < 6) ? (-16 + i) : (4 + i), m, 1'b0);
            if (i == 5)  push(pack(-16, -15, -14, -13, -12, -11), 4'd6, 1'b0);
            if (i == 11) push(pack(10, 11, 12, 13, 14, 15), 4'd6, 1'b0);
        end
        idle(3);
        if (oval_cyc.size() >= 2)
            check("t2_spacing", 32'(oval_cyc[$] - oval_cyc[$-1]), 32'd6);
        else
            check("t2_oval_count", 32'(oval_cyc.size()), 32'd3);

        // T3: order 4, two samples then a lone flush.
        drive(1'b1, 7, 4'd4, 1'b0);
        drive(1'b1, -3, 4'd4, 1'b0);
        drive(1'b0, 0, 4'd4, 1'b1);
        push(pack(0, 0, 7, -3, 0, 0), 4'd2, 1'b1);
        idle(3);

        // T4: flush arriving with the completing sample is a normal completion.
        drive(1'b1, 5, 4'd3, 1'b0);
        drive(1'b1, 6, 4'd3, 1'b0);
        drive(1'b1, 9, 4'd3, 1'b1);
        push(pack(0, 0, 0, 5, 6, 9), 4'd3, 1'b0);
        idle(3);

        // T5: illegal orders drop the sample; a legal word afterwards is intact.
        drive(1'b1, 3, 4'd0, 1'b0);
        drive(1'b1, 4, 4'd7, 1'b0);
        drive(1'b1, 1, 4'd2, 1'b0);
        drive(1'b1, -1, 4'd2, 1'b0);
        push(pack(0, 0, 0, 0, 1, -1), 4'd2, 1'b0);
        idle(3);
        check("t5_oerr_count", 32'(err_seen), 32'd2);

        // Boundaries: flush with an empty word does nothing; order 1 completes at once.
        drive(1'b0, 0, 4'd3, 1'b1);
        idle(2);
        drive(1'b1, 8, 4'd1, 1'b0);
        push(pack(0, 0, 0, 0, 0, 8), 4'd1, 1'b0);
        idle(3);

        // T6: reset mid-word discards it; the next word holds only fresh samples.
        for (int i = 1; i <= 3; i++) drive(1'b1, i, 4'd5, 1'b0);
        @(posedge clk_h);
        #1;
        ival = 1'b0; rst = 1'b1;
        @(posedge clk_h);
        #1 rst = 1'b0;
        @(negedge clk_h);
        check("t6_rst_oval", {31'd0, oval}, 32'd0);
        drive(1'b1, 11, 4'd5, 1'b0);
        drive(1'b1, 12, 4'd5, 1'b0);
        drive(1'b1, 13, 4'd5, 1'b0);
        drive(1'b1, 14, 4'd5, 1'b0);
        drive(1'b1, -2, 4'd5, 1'b0);
        push(pack(0, 11, 12, 13, 14, -2), 4'd5, 1'b0);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("oerr_total", 32'(err_seen), 32'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
